// File: rtl/qa_cl_loader.sv
// qa_cl_loader: host-side cacheline fetch engine.
// Issues tagged reads for input then weight regions and writes responses.
module qa_cl_loader #(
    parameter int ADDR_W          = 42,
    parameter int BUFFER_DEPTH    = 256,
    parameter int MAX_OUTSTANDING = 16,
    parameter int TAG_W           = 9
) (
    input  logic                          clk,
    input  logic                          resetb,
    input  logic                          go,
    input  logic [ADDR_W-1:0]             input_base,
    input  logic [ADDR_W-1:0]             weight_base,
    input  logic [8:0]                    num_cl,
    output logic                          rd_req_valid,
    input  logic                          rd_req_ready,
    output logic [ADDR_W-1:0]             rd_req_addr,
    output logic [TAG_W-1:0]              rd_req_tag,
    input  logic                          rd_rsp_valid,
    input  logic [TAG_W-1:0]              rd_rsp_tag,
    input  logic [511:0]                  rd_rsp_data,
    output logic                          buf_wr_en,
    output logic                          buffer_select,
    output logic [$clog2(BUFFER_DEPTH)-1:0] wr_addr,
    output logic [511:0]                  data,
    output logic                          conv_start,
    output logic                          busy,
    output logic                          done,
    output logic                          protocol_err
);

    localparam int IW = $clog2(BUFFER_DEPTH);
    localparam int CW = IW + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_IN,
        S_REQ_WT,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] in_base_q, in_base_d;
    logic [ADDR_W-1:0] wt_base_q, wt_base_d;
    logic [CW-1:0]     num_q, num_d;
    logic [CW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     in_rcvd_q, in_rcvd_d;
    logic [CW-1:0]     wt_rcvd_q, wt_rcvd_d;
    logic [OW-1:0]     out_q, out_d;
    logic              err_q, err_d;
    logic              conv_q, conv_d;
    logic              done_q, done_d;

    logic              wr_en_q;
    logic              sel_q;
    logic [IW-1:0]     waddr_q;
    logic [511:0]      data_q;

    logic              in_phase;
    logic              req_hs;
    logic              rsp_acc;
    logic              last_req;
    logic [CW-1:0]     num_clamp;
    logic [ADDR_W-1:0] cur_base;

    // Request-side handshake decode and read request outputs
    always_comb begin
        in_phase     = (state_q == S_REQ_IN) || (state_q == S_REQ_WT);
        rd_req_valid = in_phase && (out_q < OW'(MAX_OUTSTANDING));
        req_hs       = rd_req_valid && rd_req_ready;
        rsp_acc      = rd_rsp_valid && (out_q != '0);
        last_req     = (idx_q + CW'(1)) == num_q;
        cur_base     = (state_q == S_REQ_WT) ? wt_base_q : in_base_q;
        if (CW'(num_cl) > CW'(BUFFER_DEPTH)) begin
            num_clamp = CW'(BUFFER_DEPTH);
        end else begin
            num_clamp = CW'(num_cl);
        end
        rd_req_addr = '0;
        rd_req_tag  = '0;
        if (rd_req_valid) begin
            rd_req_addr = cur_base + ADDR_W'(idx_q);
            rd_req_tag  = {state_q == S_REQ_WT, idx_q[IW-1:0]};
        end
    end

    // Next-state: FSM, counters, launch capture and error flag
    always_comb begin
        state_d   = state_q;
        in_base_d = in_base_q;
        wt_base_d = wt_base_q;
        num_d     = num_q;
        idx_d     = idx_q;
        in_rcvd_d = in_rcvd_q;
        wt_rcvd_d = wt_rcvd_q;
        out_d     = out_q;
        err_d     = err_q;
        conv_d    = wr_en_q && !sel_q
                    && ((in_rcvd_q + CW'(1)) == num_q);
        done_d    = (state_q == S_FIN);

        if (wr_en_q) begin
            if (sel_q) begin
                wt_rcvd_d = wt_rcvd_q + CW'(1);
            end else begin
                in_rcvd_d = in_rcvd_q + CW'(1);
            end
        end

        unique case ({req_hs, rsp_acc})
            2'b10:   out_d = out_q + OW'(1);
            2'b01:   out_d = out_q - OW'(1);
            default: out_d = out_q;
        endcase

        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    in_base_d = input_base;
                    wt_base_d = weight_base;
                    num_d     = num_clamp;
                    idx_d     = '0;
                    in_rcvd_d = '0;
                    wt_rcvd_d = '0;
                    err_d     = 1'b0;
                    state_d   = (num_clamp == '0) ? S_FIN : S_REQ_IN;
                end
            end
            S_REQ_IN: begin
                if (req_hs) begin
                    if (last_req) begin
                        idx_d   = '0;
                        state_d = S_REQ_WT;
                    end else begin
                        idx_d = idx_q + CW'(1);
                    end
                end
            end
            S_REQ_WT: begin
                if (req_hs) begin
                    if (last_req) begin
                        idx_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        idx_d = idx_q + CW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (in_rcvd_q == num_q && wt_rcvd_q == num_q) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (rd_rsp_valid && out_q == '0) begin
            err_d = 1'b1;
        end
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q   <= S_IDLE;
            in_base_q <= '0;
            wt_base_q <= '0;
            num_q     <= '0;
            idx_q     <= '0;
            in_rcvd_q <= '0;
            wt_rcvd_q <= '0;
            out_q     <= '0;
            err_q     <= 1'b0;
            conv_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_base_q <= in_base_d;
            wt_base_q <= wt_base_d;
            num_q     <= num_d;
            idx_q     <= idx_d;
            in_rcvd_q <= in_rcvd_d;
            wt_rcvd_q <= wt_rcvd_d;
            out_q     <= out_d;
            err_q     <= err_d;
            conv_q    <= conv_d;
            done_q    <= done_d;
        end
    end

    // One-cycle registered buffer write for each accepted response
    always_ff @(posedge clk) begin
        if (!resetb) begin
            wr_en_q <= 1'b0;
            sel_q   <= 1'b0;
            waddr_q <= '0;
            data_q  <= '0;
        end else begin
            wr_en_q <= rsp_acc;
            if (rsp_acc) begin
                sel_q   <= rd_rsp_tag[TAG_W-1];
                waddr_q <= rd_rsp_tag[IW-1:0];
                data_q  <= rd_rsp_data;
            end
        end
    end

    assign buf_wr_en     = wr_en_q;
    assign buffer_select = sel_q;
    assign wr_addr       = waddr_q;
    assign data          = data_q;
    assign conv_start    = conv_q;
    assign done          = done_q;
    assign busy          = (state_q != S_IDLE);
    assign protocol_err  = err_q;

endmodule

// File: tb/tb_qa_cl_loader.sv
// tb_qa_cl_loader: randomized host model with scoreboard for qa_cl_loader.
// Table of launches plus hand-written reset/late-response sequence.
module tb_qa_cl_loader;

    localparam int AW = 42;

    logic          clk = 1'b0;
    logic          resetb;
    logic          go;
    logic [AW-1:0] input_base;
    logic [AW-1:0] weight_base;
    logic [8:0]    num_cl;
    logic          rd_req_valid;
    logic          rd_req_ready;
    logic [AW-1:0] rd_req_addr;
    logic [8:0]    rd_req_tag;
    logic          rd_rsp_valid;
    logic [8:0]    rd_rsp_tag;
    logic [511:0]  rd_rsp_data;
    logic          buf_wr_en;
    logic          buffer_select;
    logic [7:0]    wr_addr;
    logic [511:0]  data;
    logic          conv_start;
    logic          busy;
    logic          done;
    logic          protocol_err;

    int n_assert = 0;
    int n_fail   = 0;

    logic [8:0] force_q[$];

    always #5 clk = ~clk;

    qa_cl_loader dut (
        .clk          (clk),
        .resetb       (resetb),
        .go           (go),
        .input_base   (input_base),
        .weight_base  (weight_base),
        .num_cl       (num_cl),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_req_addr  (rd_req_addr),
        .rd_req_tag   (rd_req_tag),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_tag   (rd_rsp_tag),
        .rd_rsp_data  (rd_rsp_data),
        .buf_wr_en    (buf_wr_en),
        .buffer_select(buffer_select),
        .wr_addr      (wr_addr),
        .data         (data),
        .conv_start   (conv_start),
        .busy         (busy),
        .done         (done),
        .protocol_err (protocol_err)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_w(input string nm, input logic [511:0] act,
                         input logic [511:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] rnd_line();
        logic [511:0] v;
        for (int j = 0; j < 16; j++) v[j*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [AW-1:0] rnd_addr();
        logic [63:0] v;
        v = {$urandom, $urandom};
        return v[AW-1:0];
    endfunction

    task automatic idle_inputs();
        go           = 1'b0;
        rd_req_ready = 1'b0;
        rd_rsp_valid = 1'b0;
        rd_rsp_tag   = '0;
        rd_rsp_data  = '0;
    endtask

    // One launch against a host that accepts requests with probability
    // rdy%, returns one pending line per cycle with probability rsp%.
    task automatic run_launch(input logic [AW-1:0] ib,
                              input logic [AW-1:0] wb,
                              input int ncl, input int rdy, input int rsp,
                              input bit ooo,
                              output int reqs, output int convs);
        int n, issued, rdone, outst, inw, cyc, k;
        bit wexp, csexp, csnext, fin;
        logic [AW-1:0] ea[$];
        logic [8:0]    et[$];
        logic [8:0]    pend[$];
        logic [8:0]    t, wtag;
        logic [511:0]  wdat;
        n = (ncl > 256) ? 256 : ncl;
        for (int i = 0; i < n; i++) begin
            ea.push_back(ib + AW'(i));
            et.push_back(9'(i));
        end
        for (int i = 0; i < n; i++) begin
            ea.push_back(wb + AW'(i));
            et.push_back(9'h100 | 9'(i));
        end
        issued = 0; rdone = 0; inw = 0; convs = 0;
        wexp = 0; csexp = 0; fin = 0; wtag = '0; wdat = '0;
        @(negedge clk);
        go = 1'b1;
        input_base = ib;
        weight_base = wb;
        num_cl = 9'(ncl);
        @(negedge clk);
        go = 1'b0;
        input_base = rnd_addr();
        weight_base = rnd_addr();
        num_cl = 9'($urandom_range(511));
        cyc = 1;
        while (!fin && cyc < 20000) begin
            chk("buf_wr_en", buf_wr_en, wexp);
            csnext = 0;
            if (wexp) begin
                chk("buffer_select", buffer_select, wtag[8]);
                chk("wr_addr", wr_addr, wtag[7:0]);
                chk_w("data", data, wdat);
                if (!wtag[8]) begin
                    inw++;
                    csnext = (inw == n);
                end
            end
            chk("conv_start", conv_start, csexp);
            if (conv_start) convs++;
            csexp = csnext;
            chk("protocol_err", protocol_err, 1'b0);
            chk("busy", busy, !done);
            if (n == 0 && cyc == 2) chk("done_latency_n0", done, 1'b1);
            if (done) chk("done_after_all", issued - rdone, 0);
            if (done || (n == 0 && cyc >= 2)) begin
                fin = 1;
                idle_inputs();
            end else begin
                outst = issued - rdone;
                chk("rd_req_valid", rd_req_valid,
                    (issued < 2 * n) && (outst < 16));
                rd_rsp_valid = 1'b0;
                wexp = 0;
                if (pend.size() > 0 && $urandom_range(99) < rsp) begin
                    k = -1;
                    if (force_q.size() > 0) begin
                        for (int i = 0; i < pend.size(); i++)
                            if (pend[i] == force_q[0]) k = i;
                    end else begin
                        k = ooo ? $urandom_range(pend.size() - 1) : 0;
                    end
                    if (k >= 0) begin
                        t = pend[k];
                        pend.delete(k);
                        if (force_q.size() > 0) void'(force_q.pop_front());
                        wdat = rnd_line();
                        wtag = t;
                        rd_rsp_valid = 1'b1;
                        rd_rsp_tag = t;
                        rd_rsp_data = wdat;
                        wexp = 1;
                        rdone++;
                    end
                end
                rd_req_ready = ($urandom_range(99) < rdy);
                if (rd_req_valid && et.size() > 0) begin
                    chk("rd_req_addr", rd_req_addr, ea[0]);
                    chk("rd_req_tag", rd_req_tag, et[0]);
                    if (rd_req_ready) begin
                        pend.push_back(et[0]);
                        void'(et.pop_front());
                        void'(ea.pop_front());
                        issued++;
                    end
                end
                go = busy && ($urandom_range(15) == 0);
                if (go) begin
                    input_base = rnd_addr();
                    weight_base = rnd_addr();
                    num_cl = 9'($urandom_range(511));
                end
            end
            @(negedge clk);
            cyc++;
        end
        chk("launch_finished", fin, 1'b1);
        idle_inputs();
        chk("done_one_cycle", done, 1'b0);
        chk("idle_after_done", busy, 1'b0);
        reqs = issued;
    endtask

    typedef struct {
        logic [AW-1:0] ib;
        logic [AW-1:0] wb;
        int ncl;
        int rdy;
        int rsp;
        bit ooo;
        bit forced;
        int exp_req;
        int exp_conv;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int reqs, convs, cnt;
        logic [8:0] late[5];

        vecs[0] = '{42'h100, 42'h200, 4, 100, 100, 0, 0, 8, 1};
        vecs[1] = '{42'h100, 42'h200, 3, 100, 100, 0, 1, 6, 1};
        vecs[2] = '{42'h40, 42'h9000, 32, 100, 4, 0, 0, 64, 1};
        vecs[3] = '{42'h1234, 42'h5678, 32, 30, 25, 1, 0, 64, 1};
        vecs[4] = '{42'h100, 42'h200, 0, 100, 100, 0, 0, 0, 0};
        vecs[5] = '{42'h0, 42'h10000, 300, 85, 75, 1, 0, 512, 1};
        vecs[6] = '{42'h3FF_FFFF_FFFE, 42'h3FF_FFFF_FFFF, 5, 60, 60, 1, 0,
                    10, 1};
        vecs[7] = '{42'h77, 42'h88, 1, 50, 50, 1, 0, 2, 1};

        resetb = 1'b0;
        input_base = '0;
        weight_base = '0;
        num_cl = '0;
        idle_inputs();
        repeat (3) @(negedge clk);
        chk("rst_rd_req_valid", rd_req_valid, 1'b0);
        chk("rst_rd_req_addr", rd_req_addr, '0);
        chk("rst_rd_req_tag", rd_req_tag, '0);
        chk("rst_buf_wr_en", buf_wr_en, 1'b0);
        chk("rst_wr_addr", wr_addr, '0);
        chk_w("rst_data", data, '0);
        chk("rst_conv_start", conv_start, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_protocol_err", protocol_err, 1'b0);
        resetb = 1'b1;

        for (int v = 0; v < 8; v++) begin
            if (vecs[v].forced) begin
                force_q = '{9'h102, 9'h001, 9'h100, 9'h000, 9'h101, 9'h002};
            end
            run_launch(vecs[v].ib, vecs[v].wb, vecs[v].ncl, vecs[v].rdy,
                       vecs[v].rsp, vecs[v].ooo, reqs, convs);
            chk($sformatf("vec%0d_requests", v), reqs, vecs[v].exp_req);
            chk($sformatf("vec%0d_conv_starts", v), convs, vecs[v].exp_conv);
            force_q.delete();
        end

        // Reset mid-DRAIN with five lines outstanding
        @(negedge clk);
        go = 1'b1;
        input_base = 42'h500;
        weight_base = 42'h600;
        num_cl = 9'd4;
        rd_req_ready = 1'b1;
        @(negedge clk);
        go = 1'b0;
        cnt = 0;
        for (int c = 0; c < 50 && cnt < 8; c++) begin
            if (rd_req_valid) cnt++;
            @(negedge clk);
        end
        rd_req_ready = 1'b0;
        chk("drain_handshakes", cnt, 8);
        for (int i = 0; i < 3; i++) begin
            rd_rsp_valid = 1'b1;
            rd_rsp_tag = 9'(i);
            rd_rsp_data = rnd_line();
            @(negedge clk);
        end
        rd_rsp_valid = 1'b0;
        chk("drain_busy", busy, 1'b1);
        chk("drain_no_req", rd_req_valid, 1'b0);
        resetb = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_buf_wr_en", buf_wr_en, 1'b0);
        chk("mid_rst_rd_req_valid", rd_req_valid, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_conv_start", conv_start, 1'b0);
        chk("mid_rst_protocol_err", protocol_err, 1'b0);
        chk_w("mid_rst_data", data, '0);
        resetb = 1'b1;
        late = '{9'h003, 9'h100, 9'h101, 9'h102, 9'h103};
        for (int i = 0; i < 5; i++) begin
            rd_rsp_valid = 1'b1;
            rd_rsp_tag = late[i];
            rd_rsp_data = rnd_line();
            @(negedge clk);
            rd_rsp_valid = 1'b0;
            chk("late_rsp_no_write", buf_wr_en, 1'b0);
            chk("late_rsp_err", protocol_err, 1'b1);
        end
        @(negedge clk);
        chk("late_rsp_no_write_tail", buf_wr_en, 1'b0);
        chk("err_sticky", protocol_err, 1'b1);

        // Next launch clears the error and completes normally
        run_launch(42'h700, 42'h800, 6, 70, 60, 1, reqs, convs);
        chk("post_rst_requests", reqs, 12);
        chk("post_rst_conv_starts", convs, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
